// File: rtl/rv32i_pipeline_core.sv
// Five-stage RV32I core (IF/ID/EX/MEM/WB) with forwarding, branch flush, load-use and
// data-memory wait stalls, an ECALL drain/halt sequence and a retire port.
module rv32i_pipeline_core #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter bit          FLUSH_ON_ECALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        retire_valid,
   output logic [31:0] retire_pc,
   output logic        retire_we,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_wdata,
   output logic        halted
);
   typedef struct packed {
      logic reg_write; logic mem_read; logic mem_write; logic branch; logic jump;
      logic jalr; logic ecall; logic is_r; logic is_op; logic a_zero; logic a_pc;
   } ctrl_t;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg;
   logic        ifid_valid_reg;
   logic [31:0] ifid_pc_reg, ifid_instr_reg;
   logic        idex_valid_reg, idex_alt_reg;
   ctrl_t       idex_ctrl_reg;
   logic [31:0] idex_pc_reg, idex_a_reg, idex_b_reg, idex_imm_reg;
   logic [4:0]  idex_rs1_reg, idex_rs2_reg, idex_rd_reg;
   logic [2:0]  idex_funct3_reg;
   logic        exmem_valid_reg, exmem_reg_write_reg, exmem_mem_read_reg, exmem_mem_write_reg;
   logic [31:0] exmem_pc_reg, exmem_result_reg, exmem_store_reg;
   logic [4:0]  exmem_rd_reg;
   logic        memwb_valid_reg, memwb_reg_write_reg;
   logic [31:0] memwb_pc_reg, memwb_wdata_reg;
   logic [4:0]  memwb_rd_reg;
   logic [31:0] rf [32];

   // ---------------- ID: decode, immediate, register read ----------------
   logic [6:0]  id_op;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   ctrl_t       id_ctrl;
   logic [31:0] id_imm, id_a, id_b;
   logic        wb_we;

   assign id_op  = ifid_instr_reg[6:0];
   assign id_rd  = ifid_instr_reg[11:7];
   assign id_rs1 = ifid_instr_reg[19:15];
   assign id_rs2 = ifid_instr_reg[24:20];

   always_comb begin
      id_ctrl = '0;
      id_imm  = {{20{ifid_instr_reg[31]}}, ifid_instr_reg[31:20]};
      case (id_op)
         7'b0110011: begin id_ctrl.reg_write = 1'b1; id_ctrl.is_r = 1'b1; id_ctrl.is_op = 1'b1; end
         7'b0010011: begin id_ctrl.reg_write = 1'b1; id_ctrl.is_op = 1'b1; end
         7'b0000011: begin id_ctrl.reg_write = 1'b1; id_ctrl.mem_read = 1'b1; end
         7'b0100011: begin
            id_ctrl.mem_write = 1'b1;
            id_imm = {{20{ifid_instr_reg[31]}}, ifid_instr_reg[31:25], ifid_instr_reg[11:7]};
         end
         7'b1100011: begin
            id_ctrl.branch = 1'b1;
            id_imm = {{19{ifid_instr_reg[31]}}, ifid_instr_reg[31], ifid_instr_reg[7],
                      ifid_instr_reg[30:25], ifid_instr_reg[11:8], 1'b0};
         end
         7'b1101111: begin
            id_ctrl.jump = 1'b1; id_ctrl.reg_write = 1'b1;
            id_imm = {{11{ifid_instr_reg[31]}}, ifid_instr_reg[31], ifid_instr_reg[19:12],
                      ifid_instr_reg[20], ifid_instr_reg[30:21], 1'b0};
         end
         7'b1100111: begin id_ctrl.jalr = 1'b1; id_ctrl.reg_write = 1'b1; end
         7'b0110111: begin
            id_ctrl.reg_write = 1'b1; id_ctrl.a_zero = 1'b1;
            id_imm = {ifid_instr_reg[31:12], 12'b0};
         end
         7'b0010111: begin
            id_ctrl.reg_write = 1'b1; id_ctrl.a_pc = 1'b1;
            id_imm = {ifid_instr_reg[31:12], 12'b0};
         end
         7'b1110011: id_ctrl.ecall = 1'b1;
         default: ;
      endcase
   end

   // Register file with write-through so WB and ID can share a cycle.
   assign wb_we = memwb_valid_reg && memwb_reg_write_reg && (memwb_rd_reg != 5'd0);
   assign id_a  = (id_rs1 == 5'd0) ? 32'd0 :
                  (wb_we && memwb_rd_reg == id_rs1) ? memwb_wdata_reg : rf[id_rs1];
   assign id_b  = (id_rs2 == 5'd0) ? 32'd0 :
                  (wb_we && memwb_rd_reg == id_rs2) ? memwb_wdata_reg : rf[id_rs2];

   always_ff @(posedge clk) begin
      if (wb_we) rf[memwb_rd_reg] <= memwb_wdata_reg;
   end

   // ---------------- EX: forwarding, ALU, branch resolution ----------------
   logic        exmem_fwd_ok;
   logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_y, ex_result, redirect_pc;
   logic        taken, redirect;

   assign exmem_fwd_ok = exmem_valid_reg && exmem_reg_write_reg && !exmem_mem_read_reg &&
                         (exmem_rd_reg != 5'd0);
   assign fwd_a = (exmem_fwd_ok && exmem_rd_reg == idex_rs1_reg) ? exmem_result_reg :
                  (wb_we && memwb_rd_reg == idex_rs1_reg) ? memwb_wdata_reg : idex_a_reg;
   assign fwd_b = (exmem_fwd_ok && exmem_rd_reg == idex_rs2_reg) ? exmem_result_reg :
                  (wb_we && memwb_rd_reg == idex_rs2_reg) ? memwb_wdata_reg : idex_b_reg;
   assign alu_a = idex_ctrl_reg.a_zero ? 32'd0 : (idex_ctrl_reg.a_pc ? idex_pc_reg : fwd_a);
   assign alu_b = idex_ctrl_reg.is_r ? fwd_b : idex_imm_reg;

   always_comb begin
      alu_y = alu_a + alu_b;
      if (idex_ctrl_reg.is_op) begin
         case (idex_funct3_reg)
            3'b000:  alu_y = (idex_ctrl_reg.is_r && idex_alt_reg) ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu_y = alu_a << alu_b[4:0];
            3'b010:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, alu_a < alu_b};
            3'b100:  alu_y = alu_a ^ alu_b;
            3'b101:  alu_y = idex_alt_reg ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
            3'b110:  alu_y = alu_a | alu_b;
            default: alu_y = alu_a & alu_b;
         endcase
      end
      case (idex_funct3_reg)
         3'b000:  taken = (fwd_a == fwd_b);
         3'b001:  taken = (fwd_a != fwd_b);
         3'b100:  taken = ($signed(fwd_a) < $signed(fwd_b));
         3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
         3'b110:  taken = (fwd_a < fwd_b);
         3'b111:  taken = (fwd_a >= fwd_b);
         default: taken = 1'b0;
      endcase
   end

   assign redirect    = idex_valid_reg && (idex_ctrl_reg.jump || idex_ctrl_reg.jalr ||
                                           (idex_ctrl_reg.branch && taken));
   assign redirect_pc = idex_ctrl_reg.jalr ? ((fwd_a + idex_imm_reg) & ~32'd1)
                                           : idex_pc_reg + idex_imm_reg;
   assign ex_result   = (idex_ctrl_reg.jump || idex_ctrl_reg.jalr) ? idex_pc_reg + 32'd4 : alu_y;

   // ---------------- hazards and halt sequencing ----------------
   logic dmem_stall, load_use, ecall_ex, halt_fetch;

   assign dmem_stall = dmem_req && !dmem_ready;
   assign load_use   = idex_valid_reg && idex_ctrl_reg.mem_read && (idex_rd_reg != 5'd0) &&
                       ifid_valid_reg && (idex_rd_reg == id_rs1 || idex_rd_reg == id_rs2);
   assign ecall_ex   = idex_valid_reg && idex_ctrl_reg.ecall;
   assign halt_fetch = (state_reg != RUN) || ecall_ex;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (ecall_ex) state_next = DRAIN;
         DRAIN:   if (!idex_valid_reg && !exmem_valid_reg && !memwb_valid_reg) state_next = HALTED;
         default: state_next = HALTED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= RUN;
         pc_reg              <= RESET_PC;
         ifid_valid_reg      <= 1'b0;
         idex_valid_reg      <= 1'b0;
         idex_ctrl_reg       <= '0;
         exmem_valid_reg     <= 1'b0;
         exmem_reg_write_reg <= 1'b0;
         exmem_mem_read_reg  <= 1'b0;
         exmem_mem_write_reg <= 1'b0;
         memwb_valid_reg     <= 1'b0;
         memwb_reg_write_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (dmem_stall) begin
            // Frozen EX operands are refreshed, since the MEM/WB source they may need is bubbled.
            memwb_valid_reg     <= 1'b0;
            memwb_reg_write_reg <= 1'b0;
            idex_a_reg          <= fwd_a;
            idex_b_reg          <= fwd_b;
         end else begin
            memwb_valid_reg     <= exmem_valid_reg;
            memwb_reg_write_reg <= exmem_reg_write_reg;
            memwb_rd_reg        <= exmem_rd_reg;
            memwb_pc_reg        <= exmem_pc_reg;
            memwb_wdata_reg     <= exmem_mem_read_reg ? dmem_rdata : exmem_result_reg;

            exmem_valid_reg     <= idex_valid_reg;
            exmem_reg_write_reg <= idex_ctrl_reg.reg_write;
            exmem_mem_read_reg  <= idex_ctrl_reg.mem_read;
            exmem_mem_write_reg <= idex_ctrl_reg.mem_write;
            exmem_rd_reg        <= idex_rd_reg;
            exmem_pc_reg        <= idex_pc_reg;
            exmem_result_reg    <= ex_result;
            exmem_store_reg     <= fwd_b;

            idex_pc_reg     <= ifid_pc_reg;
            idex_a_reg      <= id_a;
            idex_b_reg      <= id_b;
            idex_imm_reg    <= id_imm;
            idex_rs1_reg    <= id_rs1;
            idex_rs2_reg    <= id_rs2;
            idex_rd_reg     <= id_rd;
            idex_funct3_reg <= ifid_instr_reg[14:12];
            idex_alt_reg    <= ifid_instr_reg[30];
            if (redirect || load_use || (halt_fetch && FLUSH_ON_ECALL)) begin
               idex_valid_reg <= 1'b0;
               idex_ctrl_reg  <= '0;
            end else begin
               idex_valid_reg <= ifid_valid_reg;
               idex_ctrl_reg  <= ifid_valid_reg ? id_ctrl : '0;
            end

            if (redirect || (halt_fetch && !load_use)) begin
               ifid_valid_reg <= 1'b0;
            end else if (!load_use) begin
               ifid_valid_reg <= 1'b1;
               ifid_pc_reg    <= pc_reg;
               ifid_instr_reg <= imem_rdata;
            end

            if (!halt_fetch) begin
               if (redirect)       pc_reg <= redirect_pc;
               else if (!load_use) pc_reg <= pc_reg + 32'd4;
            end
         end
      end
   end

   assign imem_addr    = pc_reg;
   assign dmem_req     = exmem_valid_reg && (exmem_mem_read_reg || exmem_mem_write_reg);
   assign dmem_we      = exmem_valid_reg && exmem_mem_write_reg;
   assign dmem_addr    = exmem_result_reg;
   assign dmem_wdata   = exmem_store_reg;
   assign retire_valid = memwb_valid_reg;
   assign retire_pc    = memwb_pc_reg;
   assign retire_we    = wb_we;
   assign retire_rd    = memwb_rd_reg;
   assign retire_wdata = memwb_wdata_reg;
   assign halted       = (state_reg == HALTED);
endmodule
